epidemic_forward_ctrl: RTL and testbench
========================================

Name: epidemic_forward_ctrl

Overview:
- Per-node forwarding controller for the epidemic (flooding) 2D-mesh NoC.
- Accepts one flit at a time from the node's input-side selector, then suppresses duplicates and expired flits using a seen-ID table and a TTL field.
- Replicates each surviving flit to every enabled neighbour link (l/r/t/b) except the one it arrived on.
- Holds the flit until every targeted link has completed its ready/valid handshake; links may complete on different cycles.

Parameters:
- DW, 32, flit width in bits.
- IDW, 8, packet ID width; ID occupies flit bits [IDW-1:0].
- TW, 4, TTL width; TTL occupies flit bits [IDW+TW-1:IDW].
- DEPTH, 8, number of seen-ID table entries (power of 2, >=2).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, incoming flit valid.
- i_ready, output, 1, controller can accept a flit.
- i_data, input, DW, incoming flit.
- i_src, input, 2, arrival link of the flit: 0=l, 1=r, 2=t, 3=b.
- port_en, input, 4, per-link enable (bit order l,r,t,b); edge nodes tie missing links to 0.
- o_valid, output, 4, per-link output valid (bit order l,r,t,b).
- o_ready, input, 4, per-link downstream ready.
- o_data, output, DW, flit shared by all four links.
- fwd_cnt, output, 16, count of forwarded flits; saturates at 16'hFFFF.
- drop_cnt, output, 16, count of dropped flits; saturates at 16'hFFFF.

Behaviour:
Reset (async, takes effect immediately, including mid-SEND):
- state=IDLE, i_ready=0 while rst is high, o_valid=0, o_data=0.
- All table entries invalid, write pointer=0, both counters=0.
- An in-flight flit is discarded and not counted.

IDLE:
- i_ready=1, o_valid=0.
- On i_valid&i_ready, latch i_data and i_src, then go to CHECK.

CHECK (exactly 1 cycle):
- i_ready=0, o_valid=0.
- Compute mask = port_en & ~onehot(i_src), using port_en as sampled in this cycle.
- Drop when any of the following holds: the ID matches a valid table entry; TTL==0; mask==0.
- On drop: drop_cnt++, go to IDLE, table unchanged.
- Otherwise: write the ID to the entry at the write pointer and set it valid. The pointer increments modulo DEPTH, so the oldest entry is overwritten on wrap. Load pend=mask and go to SEND.

SEND:
- i_ready=0, o_valid=pend.
- o_data = latched flit with TTL field replaced by TTL-1; all other bits unchanged.
- o_data is stable for the whole SEND state.
- Each cycle, clear pend[p] where o_valid[p]&o_ready[p]. Links complete independently; a stalled link does not block reporting on the others.
- When all remaining bits of pend complete, including several in one cycle: fwd_cnt++ and go to IDLE on the next edge. o_valid is 0 in that next cycle.
- o_ready on links not in pend is ignored. port_en changes during SEND do not alter pend.

Timing and ordering:
- Minimum latency: flit accepted on edge N, o_valid asserted from cycle N+2.
- Peak throughput: 1 flit per 3 cycles.
- Table lookup and insert never occur in the same cycle for two different flits, so there are no lookup/insert collisions.
- Counter saturation: an increment at 16'hFFFF holds the value.

Test Plan:
- Basic flood: port_en=4'b1111, flit ID=0x05, TTL=3, i_src=0 (l), all o_ready=1.
  - Required: o_valid=4'b1110 for exactly 1 cycle, 2 cycles after acceptance.
  - Required: o_data TTL=2, fwd_cnt=1, i_ready back to 1 the following cycle.
- Duplicate suppression: resend ID 0x05 from i_src=2.
  - Required: no o_valid activity, drop_cnt=1.
- Staggered ready: o_ready: r at +0, t at +3, b at +5 cycles.
  - Required: o_valid drops bit-by-bit (1110 -> 1100 -> 1000 -> 0000), o_data constant.
  - Required: i_ready=0 throughout SEND, 1 after the last handshake.
- TTL/edge drops:
  - TTL=0: dropped.
  - Corner node, port_en=4'b0010 with i_src=1: mask=0, dropped.
  - Required: drop_cnt +2 total, fwd_cnt unchanged.
- Table wrap: DEPTH=8; forward IDs 1..9.
  - Required: resending ID 1 is forwarded again (evicted by ID 9); resending ID 2 is dropped.
- Reset mid-SEND: assert rst while o_valid=4'b0110.
  - Required: o_valid=0 and counters=0 immediately, before the next clk edge.
  - After release, the same ID is forwarded (table cleared).

Source files
------------

// File: rtl/epidemic_forward_ctrl_if.sv
// Flit handshake bundle for the epidemic forwarding controller:
// single-flit input side plus the four-link replicated output side.
interface epidemic_forward_ctrl_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic [1:0]    i_src;
  logic [3:0]    o_valid;
  logic [3:0]    o_ready;
  logic [DW-1:0] o_data;

  modport slave (
    input  i_valid, i_data, i_src, o_ready,
    output i_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_src, o_ready,
    input  i_ready, o_valid, o_data
  );
endinterface

// File: rtl/epidemic_forward_ctrl.sv
// Per-node flooding controller: drops duplicate/expired flits, then
// replicates survivors to every enabled link except the arrival link.
module epidemic_forward_ctrl #(
  parameter int DW    = 32,
  parameter int IDW   = 8,
  parameter int TW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  epidemic_forward_ctrl_if.slave io,
  input  logic [3:0]             port_en,
  output logic [15:0]            fwd_cnt,
  output logic [15:0]            drop_cnt
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, SEND} state_t;

  state_t                       r_state, w_state_nxt;
  logic [DW-1:0]                r_flit, r_odata, w_fwd_data;
  logic [1:0]                   r_src;
  logic [3:0]                   r_pend, w_mask, w_pend_left;
  logic [DEPTH-1:0][IDW-1:0]    r_tab_id;
  logic [DEPTH-1:0]             r_tab_vld;
  logic [PW-1:0]                r_wptr;
  logic [15:0]                  r_fwd, r_drop;
  logic [IDW-1:0]               w_id;
  logic [TW-1:0]                w_ttl;
  logic                         w_hit, w_drop;

  assign w_id        = r_flit[IDW-1:0];
  assign w_ttl       = r_flit[IDW+TW-1:IDW];
  assign w_mask      = port_en & ~(4'b0001 << r_src);
  assign w_pend_left = r_pend & ~io.o_ready;
  assign w_drop      = w_hit | (w_ttl == '0) | (w_mask == 4'b0000);
  assign fwd_cnt     = r_fwd;
  assign drop_cnt    = r_drop;
  assign io.o_data   = r_odata;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_tab_vld[i] && (r_tab_id[i] == w_id)) w_hit = 1'b1;
  end

  always_comb begin
    w_fwd_data                   = r_flit;
    w_fwd_data[IDW+TW-1:IDW]     = w_ttl - TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // i_ready is gated by rst so nothing is accepted while reset is held
  always_comb begin
    w_state_nxt = r_state;
    io.i_ready  = 1'b0;
    io.o_valid  = 4'b0000;
    case (r_state)
      IDLE: begin
        io.i_ready = ~rst;
        if (io.i_valid) w_state_nxt = CHECK;
      end
      CHECK: w_state_nxt = w_drop ? IDLE : SEND;
      SEND: begin
        io.o_valid = r_pend;
        if (w_pend_left == 4'b0000) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit    <= '0;
      r_src     <= '0;
      r_odata   <= '0;
      r_pend    <= '0;
      r_tab_id  <= '0;
      r_tab_vld <= '0;
      r_wptr    <= '0;
      r_fwd     <= '0;
      r_drop    <= '0;
    end else begin
      case (r_state)
        IDLE: if (io.i_valid) begin
          r_flit <= io.i_data;
          r_src  <= io.i_src;
        end
        CHECK: begin
          if (w_drop) begin
            if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
          end else begin
            // FIFO replacement: wrapping pointer overwrites the oldest ID
            r_tab_id[r_wptr]  <= w_id;
            r_tab_vld[r_wptr] <= 1'b1;
            r_wptr            <= r_wptr + PW'(1);
            r_pend            <= w_mask;
            r_odata           <= w_fwd_data;
          end
        end
        SEND: begin
          r_pend <= w_pend_left;
          if ((w_pend_left == 4'b0000) && (r_fwd != 16'hFFFF)) r_fwd <= r_fwd + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_epidemic_forward_ctrl.sv
// Directed bench for epidemic_forward_ctrl: flood, duplicate, staggered
// handshakes, TTL/edge drops, table wrap and asynchronous reset mid-SEND.
module tb_epidemic_forward_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  port_en;
  logic [15:0] fwd_cnt, drop_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          seen;

  epidemic_forward_ctrl_if #(.DW(32)) bus ();

  epidemic_forward_ctrl #(.DW(32), .IDW(8), .TW(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .io(bus), .port_en(port_en),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] id, input logic [3:0] ttl);
    return {20'hABCDE, ttl, id};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns at the negedge inside the CHECK cycle
  task automatic send_flit(input logic [7:0] id, input logic [3:0] ttl, input logic [1:0] src);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = mk(id, ttl);
    bus.i_src   = src;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic run_flit(input logic [7:0] id, input logic [3:0] ttl, input logic [1:0] src,
                          output bit fwd);
    send_flit(id, ttl, src);
    fwd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_valid != 4'b0000) fwd = 1'b1;
      if (bus.i_ready) break;
    end
    chk("run_done", {31'b0, bus.i_ready}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] ev [7];
    logic [3:0] rv [7];
    ev = '{4'b1110, 4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};
    rv = '{4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};

    rst = 1'b1; port_en = 4'b1111;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_src = 2'd0; bus.o_ready = 4'b1111;
    #12;
    chk("rst_iready", {31'b0, bus.i_ready}, 32'd0);
    chk("rst_ovalid", {28'b0, bus.o_valid}, 32'd0);
    chk("rst_odata", bus.o_data, 32'd0);
    chk("rst_cnts", {fwd_cnt, drop_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_iready", {31'b0, bus.i_ready}, 32'd1);

    // basic flood
    send_flit(8'h05, 4'd3, 2'd0);
    chk("flood_chk_ovalid", {28'b0, bus.o_valid}, 32'd0);
    chk("flood_chk_iready", {31'b0, bus.i_ready}, 32'd0);
    @(negedge clk);
    chk("flood_ovalid", {28'b0, bus.o_valid}, 32'h0000_000E);
    chk("flood_odata", bus.o_data, mk(8'h05, 4'd2));
    @(negedge clk);
    chk("flood_ovalid_off", {28'b0, bus.o_valid}, 32'd0);
    chk("flood_fwd", {16'b0, fwd_cnt}, 32'd1);
    chk("flood_iready", {31'b0, bus.i_ready}, 32'd1);

    // duplicate
    run_flit(8'h05, 4'd3, 2'd2, seen);
    chk("dup_nofwd", {31'b0, seen}, 32'd0);
    chk("dup_drop", {16'b0, drop_cnt}, 32'd1);

    // staggered ready
    bus.o_ready = 4'b0000;
    send_flit(8'h10, 4'd5, 2'd0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("stag_ovalid_c%0d", c), {28'b0, bus.o_valid}, {28'b0, ev[c]});
      chk($sformatf("stag_iready_c%0d", c), {31'b0, bus.i_ready}, (c == 6) ? 32'd1 : 32'd0);
      if (c < 6) chk($sformatf("stag_odata_c%0d", c), bus.o_data, mk(8'h10, 4'd4));
      bus.o_ready = rv[c];
    end
    chk("stag_fwd", {16'b0, fwd_cnt}, 32'd2);

    // TTL and edge drops
    bus.o_ready = 4'b1111;
    run_flit(8'h20, 4'd0, 2'd1, seen);
    chk("ttl0_nofwd", {31'b0, seen}, 32'd0);
    port_en = 4'b0010;
    run_flit(8'h21, 4'd3, 2'd1, seen);
    chk("mask0_nofwd", {31'b0, seen}, 32'd0);
    chk("edge_drop", {16'b0, drop_cnt}, 32'd3);
    chk("edge_fwd", {16'b0, fwd_cnt}, 32'd2);
    port_en = 4'b1111;

    // table wrap from a clean table
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      run_flit(8'(i), 4'd7, 2'd3, seen);
      chk($sformatf("wrap_fwd_id%0d", i), {31'b0, seen}, 32'd1);
    end
    chk("wrap_fwd_cnt", {16'b0, fwd_cnt}, 32'd9);
    run_flit(8'h02, 4'd7, 2'd3, seen);
    chk("wrap_id2_drop", {31'b0, seen}, 32'd0);
    run_flit(8'h01, 4'd7, 2'd3, seen);
    chk("wrap_id1_fwd", {31'b0, seen}, 32'd1);
    chk("wrap_cnts", {fwd_cnt, drop_cnt}, {16'd10, 16'd1});

    // reset mid-SEND
    bus.o_ready = 4'b0000;
    port_en = 4'b0111;
    send_flit(8'h30, 4'd3, 2'd0);
    @(negedge clk);
    chk("mid_ovalid", {28'b0, bus.o_valid}, 32'h0000_0006);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", {28'b0, bus.o_valid}, 32'd0);
    chk("mid_rst_cnts", {fwd_cnt, drop_cnt}, 32'd0);
    chk("mid_rst_iready", {31'b0, bus.i_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    port_en = 4'b1111;
    bus.o_ready = 4'b1111;
    run_flit(8'h30, 4'd3, 2'd0, seen);
    chk("post_rst_fwd", {31'b0, seen}, 32'd1);
    chk("post_rst_cnt", {16'b0, fwd_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
